// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals of the shared memory-port arbiter.
// master = the arbiter itself; slave = the requesters plus the backing memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              err;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall_if;
  logic              stall_mem;
  logic [CNT_W-1:0]  i_grants;
  logic [CNT_W-1:0]  d_grants;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, err,
           mem_req, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem, i_grants, d_grants
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, err,
           mem_req, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem, i_grants, d_grants
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one backing-memory port between fetch (I) and memory-stage (D) requesters.
// D has priority; a saturating wait counter lets a starved I request win, and BUSY times out.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.master  bus
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam int TC_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  state_t            r_state;
  owner_t            r_owner;
  logic [SC_W-1:0]   r_starve_cnt;
  logic [TC_W-1:0]   r_tmo_cnt;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_i_ack;
  logic              r_d_ack;
  logic              r_err;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic [CNT_W-1:0]  r_i_grants;
  logic [CNT_W-1:0]  r_d_grants;

  logic              w_i_starved;
  logic              w_grant_d;
  logic              w_grant_i;
  logic              w_i_in_service;
  logic              w_tmo_hit;
  logic              w_done;
  logic [DATA_W-1:0] w_resp_data;

  assign w_i_starved    = bus.i_req && (r_starve_cnt >= SC_W'(STARVE_MAX));
  assign w_grant_d      = (r_state == S_IDLE) && bus.d_req && !w_i_starved;
  assign w_grant_i      = (r_state == S_IDLE) && bus.i_req && !w_grant_d;
  // An I request that is already being served is not waiting, so it must not accrue priority.
  assign w_i_in_service = (r_state != S_IDLE) && (r_owner == OWN_I);

  assign w_tmo_hit   = (r_tmo_cnt == TC_W'(TIMEOUT - 1));
  assign w_done      = bus.mem_ready || w_tmo_hit;
  assign w_resp_data = bus.mem_ready ? bus.mem_rdata : '0;

  always_ff @(posedge clk) begin
    // NOTE: payload and read-data registers are reset too, so a reset mid-transaction
    // leaves no stale request, ack or data behind.
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_I;
      r_starve_cnt <= '0;
      r_tmo_cnt    <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_i_ack      <= 1'b0;
      r_d_ack      <= 1'b0;
      r_err        <= 1'b0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
      r_i_grants   <= '0;
      r_d_grants   <= '0;
    end else begin
      if (!bus.i_req || w_grant_i) begin
        r_starve_cnt <= '0;
      end else if (!w_i_in_service && (r_starve_cnt < SC_W'(STARVE_MAX))) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_grant_d) begin
            r_owner     <= OWN_D;
            r_mem_we    <= bus.d_we;
            r_mem_addr  <= bus.d_addr;
            r_mem_wdata <= bus.d_wdata;
            r_d_grants  <= r_d_grants + 1'b1;
            r_mem_req   <= 1'b1;
            r_tmo_cnt   <= '0;
            r_state     <= S_BUSY;
          end else if (w_grant_i) begin
            r_owner     <= OWN_I;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= bus.i_addr;
            r_mem_wdata <= '0;
            r_i_grants  <= r_i_grants + 1'b1;
            r_mem_req   <= 1'b1;
            r_tmo_cnt   <= '0;
            r_state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_done) begin
            r_mem_req <= 1'b0;
            r_err     <= !bus.mem_ready;
            r_state   <= S_RESP;
            if (r_owner == OWN_D) begin
              r_d_ack   <= 1'b1;
              r_d_rdata <= w_resp_data;
            end else begin
              r_i_ack   <= 1'b1;
              r_i_rdata <= w_resp_data;
            end
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        S_RESP: begin
          r_i_ack <= 1'b0;
          r_d_ack <= 1'b0;
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.i_ack     = r_i_ack;
  assign bus.d_ack     = r_d_ack;
  assign bus.err       = r_err;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.i_grants  = r_i_grants;
  assign bus.d_grants  = r_d_grants;
  assign bus.stall_if  = bus.i_req & ~r_i_ack;
  assign bus.stall_mem = bus.d_req & ~r_d_ack;

endmodule
